comp_stream: RTL

COMP_STREAM -- requirements
Module: comp_stream

---
 rtl/comp_pkg.sv | 15 +
 rtl/comp_core.sv | 43 ++++
 rtl/comp_stream.sv | 99 +++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the streaming comparator: op encoding and width.
package comp_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_GT = 3'd0,
        OP_GE = 3'd1,
        OP_LT = 3'd2,
        OP_LE = 3'd3,
        OP_EQ = 3'd4,
        OP_NE = 3'd5
    } op_e;

endpackage

// File: rtl/comp_core.sv
// Combinational comparator: evaluates a <op> b, flags the unused op codes.
module comp_core
    import comp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             c,
    output logic             illegal
);

    logic gt;
    logic eq;

    // Both orderings are derived from one magnitude compare plus equality.
    always_comb begin
        gt = 1'b0;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
        end else begin
            gt = a > b;
        end
        eq = (a == b);
    end

    always_comb begin
        c       = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_GT:   c = gt;
            OP_GE:   c = gt | eq;
            OP_LT:   c = ~gt & ~eq;
            OP_LE:   c = ~gt;
            OP_EQ:   c = eq;
            OP_NE:   c = ~eq;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/comp_stream.sv
// Streaming comparator: one-entry result register behind a valid/ready pair,
// plus a saturating match counter and a sticky illegal-op flag.
module comp_stream
    import comp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             c,
    output logic             op_err,
    output logic [CNT_W-1:0] match_cnt,
    input  logic             cnt_clr
);

    // Handshake: a beat transfers on an edge where valid && ready are both 1.
    // Upstream may be accepted whenever the output slot is empty or is being
    // drained in the same cycle, so s_ready looks at m_ready combinationally.

    logic             core_c;
    logic             core_illegal;
    logic             accept;

    logic             m_valid_q, m_valid_d;
    logic             c_q, c_d;
    logic             op_err_q, op_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    comp_core #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_core (
        .a       (a),
        .b       (b),
        .op      (op),
        .c       (core_c),
        .illegal (core_illegal)
    );

    assign s_ready = ~m_valid_q | m_ready;
    assign accept  = s_valid & s_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        c_d       = c_q;
        if (accept) begin
            m_valid_d = 1'b1;
            c_d       = core_c;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Clear wins over both the count update and the flag set in its cycle.
    always_comb begin
        cnt_d    = cnt_q;
        op_err_d = op_err_q;
        if (cnt_clr) begin
            cnt_d    = '0;
            op_err_d = 1'b0;
        end else if (accept) begin
            if (core_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (core_illegal) begin
                op_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            c_q       <= 1'b0;
            op_err_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            c_q       <= c_d;
            op_err_q  <= op_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign c         = c_q;
    assign op_err    = op_err_q;
    assign match_cnt = cnt_q;

endmodule
